// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake state and arbiter FSM encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IGNT = 2'b01,
    DGNT = 2'b10
  } arb_state_t;

  localparam int ARB_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data ports.
// Data has priority; a saturating counter forces a fetch grant after DPRIO_MAX data grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DPRIO_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  localparam logic [ARB_CNT_W-1:0] CNT_MAX = ARB_CNT_W'(DPRIO_MAX);

  arb_state_t           state_reg, state_next;
  logic [ARB_CNT_W-1:0] count_reg, count_next;
  logic                 dreq;

  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Completion, error and a dropped request all return to IDLE; an error retries via re-arbitration.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (dreq && !(iREN && count_reg == CNT_MAX)) begin
          state_next = DGNT;
          if (iREN && count_reg != CNT_MAX)
            count_next = count_reg + 1'b1;
        end else if (iREN) begin
          state_next = IGNT;
        end
        if (!iREN || state_next == IGNT)
          count_next = '0;
      end
      IGNT: begin
        if (!iREN || ramstate == ACCESS || ramstate == ERROR)
          state_next = IDLE;
      end
      DGNT: begin
        if (!dreq || ramstate == ACCESS || ramstate == ERROR)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are held inactive during reset so an abandoned access never completes.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    if (!RST) begin
      case (state_reg)
        IGNT: begin
          ramaddr = iaddr;
          ramREN  = iREN;
          iwait   = !(iREN && ramstate == ACCESS);
        end
        DGNT: begin
          ramaddr  = daddr;
          ramstore = dstore;
          if (dWEN)
            ramWEN = 1'b1;
          else
            ramREN = dREN;
          dwait = !(dreq && ramstate == ACCESS);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vector table for mem_arbiter plus a starvation-ordering sequence.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int DPRIO = 4;
  localparam logic [31:0] IA = 32'h0000_0040;
  localparam logic [31:0] DA = 32'h0000_0100;
  localparam logic [31:0] DS = 32'h0000_0012;

  logic        clk = 1'b0;
  logic        rst, i_ren, d_ren, d_wen;
  logic [31:0] i_addr, d_addr, d_store, ram_load;
  ramstate_t   ram_state;
  logic        i_wait, d_wait, ram_ren, ram_wen;
  logic [31:0] i_load, d_load, ram_addr, ram_store;

  mem_arbiter #(.DPRIO_MAX(DPRIO)) dut (
    .CLK(clk), .RST(rst),
    .iREN(i_ren), .iaddr(i_addr), .iwait(i_wait), .iload(i_load),
    .dREN(d_ren), .dWEN(d_wen), .daddr(d_addr), .dstore(d_store),
    .dwait(d_wait), .dload(d_load),
    .ramREN(ram_ren), .ramWEN(ram_wen), .ramaddr(ram_addr), .ramstore(ram_store),
    .ramload(ram_load), .ramstate(ram_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, i, dr, dw;
    logic [1:0]  rs;
    logic [31:0] load;
    logic        ren, wen, iw, dwo;
    logic [31:0] addr, store;
  } vec_t;

  vec_t tbl[$];
  int   vec_count  = 0;
  int   miss_count = 0;

  // sel: 0 = bus idle, 1 = fetch address, 2 = data address/data
  task automatic add(input logic r, input logic i, input logic dr, input logic dw,
                     input logic [1:0] rs, input logic [31:0] ld,
                     input logic ren, input logic wen, input logic iw, input logic dwo,
                     input int sel);
    vec_t v;
    v.rst = r; v.i = i; v.dr = dr; v.dw = dw; v.rs = rs; v.load = ld;
    v.ren = ren; v.wen = wen; v.iw = iw; v.dwo = dwo;
    v.addr  = (sel == 1) ? IA : (sel == 2) ? DA : 32'h0;
    v.store = (sel == 2) ? DS : 32'h0;
    tbl.push_back(v);
  endtask

  initial begin
    logic [103:0] got, exp;
    int completions;
    int cycles;
    bit is_fetch;

    rst = 1'b1; i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    i_addr = IA; d_addr = DA; d_store = DS; ram_load = '0; ram_state = FREE;

    //  rst i dr dw  rs      load          ren wen iw dw sel
    add(1, 1, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // reset held
    add(1, 1, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);
    add(0, 1, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // IDLE samples fetch
    add(0, 1, 0, 0, BUSY,   32'h0,        1, 0, 1, 1, 1);  // IGNT
    add(0, 1, 0, 0, BUSY,   32'h0,        1, 0, 1, 1, 1);
    add(0, 1, 0, 0, ACCESS, 32'hDEADBEEF, 1, 0, 0, 1, 1);  // fetch completes
    add(0, 0, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // mandatory IDLE
    add(0, 1, 0, 1, FREE,   32'h0,        0, 0, 1, 1, 0);  // simultaneous: data wins
    add(0, 1, 0, 1, BUSY,   32'h0,        0, 1, 1, 1, 2);
    add(0, 1, 0, 1, ACCESS, 32'h0,        0, 1, 1, 0, 2);  // write completes
    add(0, 1, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // IDLE then fetch
    add(0, 1, 0, 0, ACCESS, 32'h11111111, 1, 0, 0, 1, 1);
    add(0, 1, 1, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // starvation: 4 data grants
    add(0, 1, 1, 0, ACCESS, 32'h0000A001, 1, 0, 1, 0, 2);
    add(0, 1, 1, 0, FREE,   32'h0,        0, 0, 1, 1, 0);
    add(0, 1, 1, 0, ACCESS, 32'h0000A002, 1, 0, 1, 0, 2);
    add(0, 1, 1, 0, FREE,   32'h0,        0, 0, 1, 1, 0);
    add(0, 1, 1, 0, ACCESS, 32'h0000A003, 1, 0, 1, 0, 2);
    add(0, 1, 1, 0, FREE,   32'h0,        0, 0, 1, 1, 0);
    add(0, 1, 1, 0, ACCESS, 32'h0000A004, 1, 0, 1, 0, 2);
    add(0, 1, 1, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // counter at max: fetch forced
    add(0, 1, 1, 0, ACCESS, 32'h0000B001, 1, 0, 0, 1, 1);
    add(0, 1, 1, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // counter cleared: data again
    add(0, 1, 1, 0, ACCESS, 32'h0000A005, 1, 0, 1, 0, 2);
    add(0, 0, 1, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // error then retry
    add(0, 0, 1, 0, ERROR,  32'h0,        1, 0, 1, 1, 2);
    add(0, 0, 1, 0, FREE,   32'h0,        0, 0, 1, 1, 0);
    add(0, 0, 1, 0, ACCESS, 32'h0000C001, 1, 0, 1, 0, 2);
    add(0, 0, 1, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // data abort
    add(0, 0, 1, 0, BUSY,   32'h0,        1, 0, 1, 1, 2);
    add(0, 0, 0, 0, ACCESS, 32'h0,        0, 0, 1, 1, 2);
    add(0, 0, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);
    add(0, 1, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // reset mid-grant
    add(1, 1, 0, 0, ACCESS, 32'h0,        0, 0, 1, 1, 0);
    add(0, 0, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);
    add(0, 1, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);  // fetch abort
    add(0, 0, 0, 0, ACCESS, 32'h0,        0, 0, 1, 1, 1);
    add(0, 0, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);
    add(0, 0, 1, 1, FREE,   32'h0,        0, 0, 1, 1, 0);  // dWEN beats dREN
    add(0, 0, 1, 1, ACCESS, 32'h0,        0, 1, 1, 0, 2);
    add(0, 0, 0, 0, FREE,   32'h0,        0, 0, 1, 1, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      rst = tbl[k].rst; i_ren = tbl[k].i; d_ren = tbl[k].dr; d_wen = tbl[k].dw;
      ram_state = ramstate_t'(tbl[k].rs); ram_load = tbl[k].load;
      #1;
      got = {ram_ren, ram_wen, i_wait, d_wait, ram_addr, ram_store, i_load};
      exp = {tbl[k].ren, tbl[k].wen, tbl[k].iw, tbl[k].dwo, tbl[k].addr, tbl[k].store, tbl[k].load};
      vec_count++;
      if (got !== exp || d_load !== tbl[k].load) begin
        miss_count++;
        $display("FAIL vec%0d: got ren=%b wen=%b iw=%b dw=%b addr=%h st=%h il=%h dl=%h, want ren=%b wen=%b iw=%b dw=%b addr=%h st=%h ld=%h",
                 k, ram_ren, ram_wen, i_wait, d_wait, ram_addr, ram_store, i_load, d_load,
                 tbl[k].ren, tbl[k].wen, tbl[k].iw, tbl[k].dwo, tbl[k].addr, tbl[k].store, tbl[k].load);
      end else begin
        $display("vec%0d ok: ren=%b wen=%b iw=%b dw=%b addr=%h", k, ram_ren, ram_wen, i_wait, d_wait, ram_addr);
      end
    end

    // Saturated ports with immediate ACCESS: expect DPRIO data completions, then one fetch, repeating.
    @(negedge clk);
    rst = 1'b0; i_ren = 1'b1; d_ren = 1'b1; d_wen = 1'b0; ram_state = ACCESS;
    completions = 0;
    cycles = 0;
    while (completions < 2 * (DPRIO + 1) && cycles < 60) begin
      #1;
      if (!i_wait || !d_wait) begin
        is_fetch = (completions % (DPRIO + 1)) == DPRIO;
        vec_count++;
        if (i_wait == is_fetch || d_wait == !is_fetch) begin
          miss_count++;
          $display("FAIL starve%0d: got iwait=%b dwait=%b, want %s completion",
                   completions, i_wait, d_wait, is_fetch ? "fetch" : "data");
        end else begin
          $display("starve%0d ok: %s completion", completions, is_fetch ? "fetch" : "data");
        end
        completions++;
      end
      cycles++;
      @(negedge clk);
    end
    if (completions < 2 * (DPRIO + 1)) begin
      vec_count++;
      miss_count++;
      $display("FAIL starve_timeout: got %0d completions, want %0d", completions, 2 * (DPRIO + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
